inst_fetch_unit: RTL and testbench

Instruction-fetch (IF) stage of the pipelined RISC-V core. It owns the PC and drives the byte address into the combinational instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register. It supports stall, branch/jump redirect with flush, end-of-program halt, and a fetched-instruction counter.

---
 rtl/inst_fetch_unit.sv | 68 ++++++
 tb/tb_inst_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
// Supports stall, redirect with flush, halt at the final program
// instruction, and a saturating count of valid captures.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] END_ADDR = 64'd152,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic [63:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [63:0] pc;

  // Instruction memory is read in the same cycle, so the address is the PC itself.
  assign inst_addr = pc;

  // PC, IF/ID register, halt flag and fetch counter.
  // Priority: reset > redirect > stall > halted > normal advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= 64'd0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      // Targets are word aligned; stray low bits are dropped. Clearing halted
      // lets an older branch resolving after the final fetch restart the core.
      pc          <= redirect_target & ~64'd3;
      if_id_pc    <= 64'd0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (stall) begin
      pc <= pc;
    end else if (halted) begin
      if_id_pc    <= 64'd0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else begin
      if_id_pc    <= pc;
      if_id_inst  <= inst_data;
      if_id_valid <= 1'b1;
      if (fetch_count != 32'hFFFFFFFF) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (pc == END_ADDR) begin
        halted <= 1'b1;
      end else begin
        pc <= pc + 64'd4;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational memory model.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] inst_addr;
  logic [31:0] inst_data;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  inst_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .inst_addr       (inst_addr),
    .inst_data       (inst_data),
    .if_id_pc        (if_id_pc),
    .if_id_inst      (if_id_inst),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word for an address: distinct per address, never equal to NOP.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A5A0000;
  endfunction

  assign inst_data = mem(inst_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [63:0] addr, input logic [63:0] ipc,
                           input logic [31:0] inst, input logic vld, input logic hlt,
                           input logic [31:0] cnt);
    chk({tag, ".inst_addr"}, inst_addr, addr);
    chk({tag, ".if_id_pc"}, if_id_pc, ipc);
    chk({tag, ".if_id_inst"}, {32'd0, if_id_inst}, {32'd0, inst});
    chk({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, vld});
    chk({tag, ".halted"}, {63'd0, halted}, {63'd0, hlt});
    chk({tag, ".count"}, {32'd0, fetch_count}, {32'd0, cnt});
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 64'd0;
    tick; tick;
    chk_state("reset", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;

    // Free run
    tick; chk_state("run1", 64'd4, 64'd0, mem(64'd0), 1'b1, 1'b0, 32'd1);
    tick; chk_state("run2", 64'd8, 64'd4, mem(64'd4), 1'b1, 1'b0, 32'd2);

    // Stall holds everything
    stall = 1'b1;
    tick; chk_state("stall1", 64'd8, 64'd4, mem(64'd4), 1'b1, 1'b0, 32'd2);
    tick; chk_state("stall2", 64'd8, 64'd4, mem(64'd4), 1'b1, 1'b0, 32'd2);
    stall = 1'b0;
    tick; chk_state("unstall", 64'd12, 64'd8, mem(64'd8), 1'b1, 1'b0, 32'd3);

    // Redirect wins over stall
    stall = 1'b1; redirect = 1'b1; redirect_target = 64'h24;
    tick; chk_state("redir_stall", 64'h24, 64'd0, NOP, 1'b0, 1'b0, 32'd3);
    stall = 1'b0; redirect = 1'b0;
    tick; chk_state("after_redir", 64'h28, 64'h24, mem(64'h24), 1'b1, 1'b0, 32'd4);

    // Unaligned target and wrap-around
    redirect = 1'b1; redirect_target = 64'h27;
    tick; chk("align.inst_addr", inst_addr, 64'h24);
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick; chk_state("redir_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, NOP, 1'b0, 1'b0, 32'd4);
    redirect = 1'b0;
    tick; chk_state("wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, mem(64'hFFFF_FFFF_FFFF_FFFC),
                    1'b1, 1'b0, 32'd5);

    // Run up to the final instruction
    for (int i = 0; i < 38; i++) begin
      tick;
      chk("walk.inst_addr", inst_addr, 64'(4 * (i + 1)));
    end
    chk_state("at_end", 64'd152, 64'd148, mem(64'd148), 1'b1, 1'b0, 32'd43);
    tick; chk_state("halt", 64'd152, 64'd152, mem(64'd152), 1'b1, 1'b1, 32'd44);
    tick; chk_state("halt_bubble", 64'd152, 64'd0, NOP, 1'b0, 1'b1, 32'd44);
    tick; chk_state("halt_hold", 64'd152, 64'd0, NOP, 1'b0, 1'b1, 32'd44);

    // Redirect out of halt
    redirect = 1'b1; redirect_target = 64'h58;
    tick; chk_state("unhalt", 64'h58, 64'd0, NOP, 1'b0, 1'b0, 32'd44);
    redirect = 1'b0;
    tick; chk_state("resume", 64'h5C, 64'h58, mem(64'h58), 1'b1, 1'b0, 32'd45);

    // Redirect while pc == END_ADDR suppresses halt
    redirect = 1'b1; redirect_target = 64'd152;
    tick; chk("to_end.inst_addr", inst_addr, 64'd152);
    redirect_target = 64'h10;
    tick; chk_state("no_halt", 64'h10, 64'd0, NOP, 1'b0, 1'b0, 32'd45);

    // Halt again, then reset while halted and stalled
    redirect_target = 64'd152;
    tick;
    redirect = 1'b0;
    tick; chk_state("halt2", 64'd152, 64'd152, mem(64'd152), 1'b1, 1'b1, 32'd46);
    stall = 1'b1;
    tick; chk_state("halt2_stall", 64'd152, 64'd152, mem(64'd152), 1'b1, 1'b1, 32'd46);
    reset = 1'b0;
    tick; chk_state("reset2", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    reset = 1'b1; stall = 1'b0;
    tick; chk_state("post_reset", 64'd4, 64'd0, mem(64'd0), 1'b1, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
